// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: CPU request bus plus memory-side port of the data memory controller
interface data_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      i_req;
    logic [ADDR_WIDTH-1:0]     i_addr;
    logic [1:0]                i_access;
    logic                      i_unsigned;
    logic                      i_wrEnable;
    logic [DATA_WIDTH-1:0]     i_wrData;
    logic [DATA_WIDTH-1:0]     o_rdData;
    logic                      o_ready;
    logic                      o_busy;
    logic                      o_error;
    logic [ADDR_WIDTH-1:0]     o_memAddr;
    logic [DATA_WIDTH-1:0]     o_memWrData;
    logic [DATA_WIDTH/8-1:0]   o_memByteEnable;
    logic                      o_memWrEnable;
    logic                      o_memRdEnable;
    logic [DATA_WIDTH-1:0]     i_memRdData;
    modport slave (
        input  i_req, i_addr, i_access, i_unsigned, i_wrEnable, i_wrData, i_memRdData,
        output o_rdData, o_ready, o_busy, o_error, o_memAddr, o_memWrData,
               o_memByteEnable, o_memWrEnable, o_memRdEnable
    );
    modport master (
        output i_req, i_addr, i_access, i_unsigned, i_wrEnable, i_wrData, i_memRdData,
        input  o_rdData, o_ready, o_busy, o_error, o_memAddr, o_memWrData,
               o_memByteEnable, o_memWrEnable, o_memRdEnable
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: sized/aligned load-store unit driving a wait-stated data memory
module data_mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input logic i_clock,
    input logic i_reset,
    data_mem_ctrl_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    logic [1:0]            state;
    logic [3:0]            count;
    logic [1:0]            reqAccess;
    logic                  reqUnsigned;
    logic                  errFlag;
    logic [OW-1:0]         reqOffset;
    logic [OW-1:0]         inOffset;
    logic [OW-1:0]         sizeMask;
    logic [NB-1:0]         lowBe;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] replData;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] readMask;
    logic [DATA_WIDTH-1:0] extended;
    logic                  signBit;
    assign bus.o_ready = state == DONE;
    assign bus.o_error = state == DONE && errFlag;
    assign bus.o_busy  = state != IDLE;
    // request decode: legality, lane strobes and write-data replication from the live inputs
    always_comb begin
        inOffset = bus.i_addr[OW-1:0];
        sizeMask = OW'((32'd1 << bus.i_access) - 32'd1);
        lowBe    = NB'((32'd1 << (32'd1 << bus.i_access)) - 32'd1);
        illegal  = (bus.i_access == 2'd3 && DATA_WIDTH == 32) || (inOffset & sizeMask) != '0;
        replData = '0;
        for (int i = 0; i < NB; i++)
            replData[8*i +: 8] = bus.i_wrData[8*int'(OW'(i) & sizeMask) +: 8];
    end
    // read alignment: shift the lane down, mask to size, extend from the top kept bit
    always_comb begin
        shifted  = bus.i_memRdData >> {reqOffset, 3'b000};
        readMask = ~({DATA_WIDTH{1'b1}} << (32'd8 << reqAccess));
        signBit  = |(shifted & (readMask ^ (readMask >> 1)));
        extended = (signBit && !reqUnsigned) ? (shifted | ~readMask) : (shifted & readMask);
    end
    // IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE, or IDLE -> DONE for an illegal request
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state                <= IDLE;
            count                <= '0;
            reqAccess            <= '0;
            reqUnsigned          <= 1'b0;
            reqOffset            <= '0;
            errFlag              <= 1'b0;
            bus.o_rdData         <= '0;
            bus.o_memAddr        <= '0;
            bus.o_memByteEnable  <= '0;
            bus.o_memWrData      <= '0;
            bus.o_memWrEnable    <= 1'b0;
            bus.o_memRdEnable    <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.i_req) begin
                state               <= illegal ? DONE : ACCESS;
                errFlag             <= illegal;
                count               <= WS;
                reqAccess           <= bus.i_access;
                reqUnsigned         <= bus.i_unsigned;
                reqOffset           <= inOffset;
                bus.o_rdData        <= illegal ? '0 : bus.o_rdData;
                bus.o_memAddr       <= illegal ? '0 : {bus.i_addr[ADDR_WIDTH-1:OW], OW'(0)};
                bus.o_memByteEnable <= illegal ? '0 : lowBe << inOffset;
                bus.o_memWrData     <= illegal ? '0 : replData;
                bus.o_memWrEnable   <= !illegal && bus.i_wrEnable;
                bus.o_memRdEnable   <= !illegal && !bus.i_wrEnable;
            end
        end else if (state == ACCESS) begin
            if (count == '0) begin
                state               <= DONE;
                bus.o_rdData        <= bus.o_memRdEnable ? extended : bus.o_rdData;
                bus.o_memAddr       <= '0;
                bus.o_memByteEnable <= '0;
                bus.o_memWrData     <= '0;
                bus.o_memWrEnable   <= 1'b0;
                bus.o_memRdEnable   <= 1'b0;
            end else begin
                count <= count - 4'd1;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule
